// File: rtl/fp_conv_pkg.sv
// Shared widths, FSM encoding and IEEE-754 helpers for the fixed-to-float converter scheduler.
package fp_conv_pkg;

    localparam int INT_W    = 8;
    localparam int POINT_W  = 3;
    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int EXP_BIAS = 127;
    localparam int MANT_W   = 23;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StWait = WAIT,
        StResp = RESP
    } state_e;

    // Signed zero: the only result the scheduler can produce without the converter.
    function automatic logic [FP_W-1:0] fp_zero(input logic sign);
        return {sign, {(FP_W-1){1'b0}}};
    endfunction

    // Value = (-1)^sign * mag / 2^point, always exactly representable in single precision.
    function automatic logic [FP_W-1:0] fix_to_fp(input logic [INT_W-1:0]   mag,
                                                  input logic [POINT_W-1:0] point,
                                                  input logic               sign);
        logic [FP_W-1:0]   res;
        logic [EXP_W-1:0]  expo;
        logic [MANT_W:0]   ext;
        int                msb;
        res = fp_zero(sign);
        msb = -1;
        for (int i = 0; i < INT_W; i++) begin
            if (mag[i]) msb = i;
        end
        if (msb >= 0) begin
            expo = EXP_W'(msb - int'(point) + EXP_BIAS);
            ext  = (MANT_W+1)'(mag) << (MANT_W - msb);
            res  = {sign, expo, ext[MANT_W-1:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_conv_scheduler_if.sv
// Requester and converter bus of the scheduler; slave is the scheduler, master the environment.
interface fp_conv_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    import fp_conv_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [INT_W*NUM_REQ-1:0]   req_int;
    logic [POINT_W*NUM_REQ-1:0] req_point;
    logic [NUM_REQ-1:0]         req_sign;
    logic [NUM_REQ-1:0]         req_ready;

    logic [INT_W-1:0]           conv_int;
    logic [POINT_W-1:0]         conv_point;
    logic                       conv_sign;
    logic                       conv_start;
    logic [FP_W-1:0]            conv_data;

    logic                       resp_valid;
    logic [ID_W-1:0]            resp_id;
    logic [FP_W-1:0]            resp_data;

    modport slave (
        input  req_valid, req_int, req_point, req_sign, conv_data,
        output req_ready, conv_int, conv_point, conv_sign, conv_start,
        output resp_valid, resp_id, resp_data
    );

    modport master (
        output req_valid, req_int, req_point, req_sign, conv_data,
        input  req_ready, conv_int, conv_point, conv_sign, conv_start,
        input  resp_valid, resp_id, resp_data
    );

endinterface

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping modulo N.
module fp_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int unsigned IDX_W = $clog2(N);

    int unsigned      idx;
    logic [IDX_W-1:0] sel;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) idx = idx - N;
            sel = IDX_W'(idx);
            if (enable && !found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/fp_conv_scheduler.sv
// Round-robin scheduler sharing one fixed-latency fixed-to-float converter between requesters.
// Optional: define FP_CONV_SCHED_ZERO_BYPASS_EN to answer zero-magnitude operands without the converter.
module fp_conv_scheduler
    import fp_conv_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CONV_LATENCY = 10
) (
    input  logic              clk,
    input  logic              rst,
    fp_conv_scheduler_if.slave bus,
    output logic              busy
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(CONV_LATENCY + 1);

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    owner_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               arb_en;
    logic               accept;
    logic               bypass;
    logic [INT_W-1:0]   win_int;
    logic [POINT_W-1:0] win_point;
    logic               win_sign;

    // Grant is suppressed during the reset cycle so no requester sees a phantom accept.
    assign arb_en = (state_q == StIdle) && !rst;

    fp_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (win_idx)
    );

    assign bus.req_ready = grant;
    assign accept        = |grant;
    assign busy          = (state_q != StIdle);

    always_comb begin
        win_int   = '0;
        win_point = '0;
        win_sign  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                win_int   = bus.req_int[i*INT_W +: INT_W];
                win_point = bus.req_point[i*POINT_W +: POINT_W];
                win_sign  = bus.req_sign[i];
            end
        end
    end

`ifdef FP_CONV_SCHED_ZERO_BYPASS_EN
    assign bypass = (win_int == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            owner_q        <= '0;
            cnt_q          <= '0;
            bus.conv_int   <= '0;
            bus.conv_point <= '0;
            bus.conv_sign  <= 1'b0;
            bus.conv_start <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_data  <= '0;
        end else begin
            bus.conv_start <= 1'b0;
            bus.resp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        bus.conv_int   <= win_int;
                        bus.conv_point <= win_point;
                        bus.conv_sign  <= win_sign;
                        owner_q        <= win_idx;
                        cnt_q          <= '0;
                        ptr_q          <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                          : win_idx + ID_W'(1);
                        if (bypass) begin
                            state_q        <= StResp;
                            bus.resp_valid <= 1'b1;
                            bus.resp_id    <= win_idx;
                            bus.resp_data  <= fp_zero(win_sign);
                        end else begin
                            state_q        <= StWait;
                            bus.conv_start <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    // Capture on the edge ending the CONV_LATENCY-th WAIT cycle.
                    if (cnt_q == CNT_W'(CONV_LATENCY - 1)) begin
                        state_q        <= StResp;
                        bus.resp_valid <= 1'b1;
                        bus.resp_id    <= owner_q;
                        bus.resp_data  <= bus.conv_data;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_conv_scheduler.sv
// Directed bench for fp_conv_scheduler with a latency-accurate converter stub and a response scoreboard.
module tb_fp_conv_scheduler;
    import fp_conv_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 10;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    exp_t sb[$];

    logic stub_on;
    int   stub_cnt;

    fp_conv_scheduler_if #(.NUM_REQ(NREQ)) bus ();

    fp_conv_scheduler #(
        .NUM_REQ      (NREQ),
        .CONV_LATENCY (LAT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Converter stub: result is garbage until LAT cycles after conv_start, then stays valid.
    always @(posedge clk) begin
        if (rst) begin
            stub_on  <= 1'b0;
            stub_cnt <= 0;
        end else if (bus.conv_start) begin
            stub_on  <= 1'b1;
            stub_cnt <= 1;
        end else if (stub_on && stub_cnt < 1000) begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    assign bus.conv_data = (stub_on && !bus.conv_start && stub_cnt >= int'(LAT) - 1)
                           ? fix_to_fp(bus.conv_int, bus.conv_point, bus.conv_sign)
                           : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic goto_cycle(input int c);
        while (cyc < c) next_cycle();
    endtask

    task automatic expect_resp(input int id, input logic [31:0] d, input int at);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            next_cycle();
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic set_op(input int i, input logic [7:0] m, input logic [2:0] p, input logic s);
        bus.req_int[8*i +: 8]   = m;
        bus.req_point[3*i +: 3] = p;
        bus.req_sign[i]         = s;
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_id", 32'(bus.resp_id), 32'(e.id));
                check("resp_data", bus.resp_data, e.data);
                check("resp_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d responses pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_int   = '1;
        bus.req_point = '0;
        bus.req_sign  = '0;

        // Reset: outputs cleared, grant held low even with every request raised.
        next_cycle();
        next_cycle();
        mid();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_conv_start", 32'(bus.conv_start), 32'd0);
        check("rst_conv_int", 32'(bus.conv_int), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        next_cycle();
        bus.req_valid = '0;
        rst           = 1'b0;

        // Test 1: single request from 2.
        set_op(2, 8'h06, 3'd1, 1'b0);
        bus.req_valid[2] = 1'b1;
        c0 = cyc;
        expect_resp(2, 32'h4040_0000, c0 + 11);
        mid();
        check("t1_ready", 32'(bus.req_ready), 32'b0100);
        next_cycle();
        bus.req_valid[2] = 1'b0;
        mid();
        check("t1_conv_start", 32'(bus.conv_start), 32'd1);
        check("t1_conv_int", 32'(bus.conv_int), 32'h06);
        check("t1_conv_point", 32'(bus.conv_point), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        next_cycle();
        mid();
        check("t1_conv_start_low", 32'(bus.conv_start), 32'd0);
        drain(30);

        // Test 2: all four requesting from ptr=0.
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 8'(8'h11 * (i + 1)), 3'(i + 1), i[0]);
        bus.req_valid = 4'b1111;
        c0 = cyc;
        for (int k = 0; k < 5; k++) begin
            expect_resp(k % 4, fix_to_fp(8'(8'h11 * (k % 4 + 1)), 3'(k % 4 + 1), k[0]),
                        c0 + 12 * k + 11);
        end
        for (int k = 0; k < 5; k++) begin
            goto_cycle(c0 + 12 * k);
            mid();
            check("t2_grant", 32'(bus.req_ready), 32'd1 << (k % 4));
            check("t2_busy_idle", 32'(busy), 32'd0);
        end
        next_cycle();
        bus.req_valid = '0;
        drain(20);

        // Test 3: operand held through WAIT; others toggling see no grant.
        set_op(1, 8'h5A, 3'd3, 1'b1);
        bus.req_valid[1] = 1'b1;
        c0 = cyc;
        expect_resp(1, fix_to_fp(8'h5A, 3'd3, 1'b1), c0 + 11);
        mid();
        check("t3_ready", 32'(bus.req_ready), 32'b0010);
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            if (i == 1) begin
                bus.req_valid[1]    = 1'b0;
                bus.req_int[15:8]   = 8'hFF;
            end
            bus.req_valid[0] = i[0];
            bus.req_valid[2] = i[0];
            bus.req_valid[3] = i[0];
            mid();
            check("t3_ready_wait", 32'(bus.req_ready), 32'd0);
            check("t3_conv_int", 32'(bus.conv_int), 32'h5A);
        end
        next_cycle();
        bus.req_valid = '0;
        drain(20);

        // Test 4: reset in cycle T+5 drops the conversion and clears ptr.
        set_op(2, 8'h81, 3'd0, 1'b0);
        bus.req_valid[2] = 1'b1;
        c0 = cyc;
        mid();
        check("t4_ready", 32'(bus.req_ready), 32'b0100);
        next_cycle();
        bus.req_valid[2] = 1'b0;
        goto_cycle(c0 + 5);
        rst = 1'b1;
        mid();
        check("t4_busy_before", 32'(busy), 32'd1);
        next_cycle();
        rst = 1'b0;
        set_op(1, 8'h03, 3'd2, 1'b0);
        set_op(3, 8'hC0, 3'd7, 1'b1);
        bus.req_valid = 4'b1010;
        c1 = cyc;
        expect_resp(1, fix_to_fp(8'h03, 3'd2, 1'b0), c1 + 11);
        expect_resp(3, fix_to_fp(8'hC0, 3'd7, 1'b1), c1 + 23);
        mid();
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_conv_int_clr", 32'(bus.conv_int), 32'd0);
        check("t4_ptr_reset", 32'(bus.req_ready), 32'b0010);
        next_cycle();
        bus.req_valid[1] = 1'b0;
        goto_cycle(c1 + 12);
        mid();
        check("t4_grant3", 32'(bus.req_ready), 32'b1000);
        next_cycle();
        bus.req_valid[3] = 1'b0;
        drain(30);

        // Test 5: zero operand, sign set.
        set_op(0, 8'h00, 3'd2, 1'b1);
        bus.req_valid[0] = 1'b1;
        c0 = cyc;
`ifdef FP_CONV_SCHED_ZERO_BYPASS_EN
        expect_resp(0, 32'h8000_0000, c0 + 1);
`else
        expect_resp(0, 32'h8000_0000, c0 + 11);
`endif
        mid();
        check("t5_ready", 32'(bus.req_ready), 32'b0001);
        next_cycle();
        bus.req_valid[0] = 1'b0;
        mid();
`ifdef FP_CONV_SCHED_ZERO_BYPASS_EN
        check("t5_conv_start", 32'(bus.conv_start), 32'd0);
`else
        check("t5_conv_start", 32'(bus.conv_start), 32'd1);
`endif
        check("t5_conv_sign", 32'(bus.conv_sign), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
        drain(30);

        // Test 6: requester 1 re-requesting back to back.
        set_op(1, 8'hA0, 3'd4, 1'b0);
        bus.req_valid[1] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) expect_resp(1, fix_to_fp(8'hA0, 3'd4, 1'b0), c0 + 12 * k + 11);
        for (int c = 0; c <= 24; c++) begin
            mid();
            check("t6_busy", 32'(busy), (c % 12 == 0) ? 32'd0 : 32'd1);
            if (c % 12 == 0) check("t6_grant", 32'(bus.req_ready), 32'b0010);
            next_cycle();
        end
        bus.req_valid[1] = 1'b0;
        drain(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fp_conv_scheduler.md
Name: fp_conv_scheduler

Overview:
Shares one multi-cycle fixed-to-float converter between NUM_REQ requesters. It grants one requester at a time using round-robin arbitration and holds that requester's operand (8-bit magnitude, 3-bit binary-point position, sign) stable on the converter inputs. It waits a fixed CONV_LATENCY cycles, then captures the 32-bit IEEE-754 single result and returns it to the granted requester with a one-cycle valid pulse and requester ID. It sits between the request sources and the floating-point converter datapath.

Parameters:
NUM_REQ, 4, number of requesters; must be >= 2.
CONV_LATENCY, 10, cycles from conv_start until conv_data is valid and stable; must be >= 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request; held with operand until accepted
req_int  input  8*NUM_REQ  per-requester magnitude; slice i = [8i+7:8i]
req_point  input  3*NUM_REQ  per-requester binary-point position
req_sign  input  NUM_REQ  per-requester sign
req_ready  output  NUM_REQ  one-hot grant; accept occurs when req_valid[i] and req_ready[i] are both high
conv_int  output  8  registered operand to converter
conv_point  output  3  registered operand to converter
conv_sign  output  1  registered operand to converter
conv_start  output  1  one-cycle pulse marking a new operand
conv_data  input  32  converter result
resp_valid  output  1  one-cycle result pulse
resp_id  output  $clog2(NUM_REQ)  index of the requester owning resp_data
resp_data  output  32  captured result
busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states:
  - IDLE: req_ready may be non-zero.
  - WAIT: operand held; cycle counter running.
  - RESP: resp_valid=1 for exactly one cycle.
- Transitions: IDLE -> WAIT on accept; WAIT -> RESP when cnt == CONV_LATENCY-1; RESP -> IDLE unconditionally.
- req_ready is combinational from req_valid and the RR pointer, and is zero outside IDLE.
- Arbitration: search starts at ptr and wraps modulo NUM_REQ. On accept, ptr <= winner+1 (wrapping NUM_REQ-1 to 0). ptr is unchanged when nothing is accepted.
- Timing, with accept at the edge ending cycle T:
  - Cycle T+1: conv_* hold the winner's operand; conv_start=1.
  - Cycles T+1..T+CONV_LATENCY: WAIT; conv_* stay stable and conv_start=0 after T+1.
  - Edge ending T+CONV_LATENCY: resp_data <= conv_data.
  - Cycle T+CONV_LATENCY+1: RESP; resp_valid=1.
  - Cycle T+CONV_LATENCY+2: IDLE; the earliest next accept.
- Throughput is one conversion per CONV_LATENCY+2 cycles.
- resp_id and resp_data hold their last values until the next capture.
- Counter is $clog2(CONV_LATENCY+1) bits and clears on entry to WAIT.
- Reset values: state=IDLE, ptr=0, cnt=0, req_ready=0 (held low during the rst cycle), conv_int=0, conv_point=0, conv_sign=0, conv_start=0, resp_valid=0, resp_id=0, resp_data=0, busy=0.
- Reset mid-operation drops the in-flight request with no response; the requester has already seen its accept.
- req_valid deasserting without accept is legal; the grant moves on next cycle.
- Operand changes while not accepted are ignored.
- All requesters active: each is served once per NUM_REQ grants, in strict index order from ptr.

Optional Feature:
FP_CONV_SCHED_ZERO_BYPASS_EN
- Defined: an accepted operand with int==0 skips the converter. Next cycle is RESP with resp_data={sign,31'b0}; no conv_start; latency is 1 cycle; conv_* are still loaded.
- Undefined: zero operands go through the converter like any other; cycle behaviour is identical to non-zero operands.

Decomposition:
- Shared package/include fp_conv_pkg holds:
  - INT_W=8, POINT_W=3, FP_W=32, EXP_BIAS=127, MANT_W=23.
  - State encoding localparams IDLE/WAIT/RESP.
- One sub-module, fp_rr_arbiter (parameter N): inputs req, ptr, enable; outputs one-hot grant and binary grant index. Purely combinational; ptr update stays in the parent.

Test Plan:
1. Single request: req 2 with int=0x06, point=1, sign=0; stub returns 0x40400000. Expect conv_start at T+1, resp_valid at T+11, resp_id=2, resp_data=0x40400000.
2. All four requesting continuously after reset (ptr=0). Expect grants in order 0,1,2,3,0, spaced 12 cycles apart; resp_id follows the same order.
3. Operand stability: the requester changes req_int after accept. conv_int must stay at the accepted value through WAIT; toggling req_valid of others in WAIT must not change req_ready (stays 0).
4. rst asserted in cycle T+5 of a conversion. Expect no resp_valid, busy=0 next cycle, ptr=0; a new request from 3 is accepted normally.
5. With FP_CONV_SCHED_ZERO_BYPASS_EN defined, int=0x00, sign=1. Expect resp_valid at T+1, resp_data=0x80000000, no conv_start. Without the macro, the stub result appears at T+11.
6. Back-to-back single requester 1, re-requesting immediately. Expect accepts exactly 12 cycles apart and busy low only in the accept cycles.
